// File: rtl/chess_clock_time_ctrl.sv
// rtl/chess_clock_time_ctrl.sv - chess clock time-control sequencer (presets, countdown, Fischer increment)
module chess_clock_time_ctrl #(
    parameter int CLK_DIV = 100_000_000,
    parameter int TW      = 12,
    parameter int BASE0   = 60,
    parameter int INC0    = 0,
    parameter int BASE1   = 180,
    parameter int INC1    = 2,
    parameter int BASE2   = 300,
    parameter int INC2    = 3,
    parameter int BASE3   = 600,
    parameter int INC3    = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_restart,
    input  logic          i_mode_next,
    input  logic          i_player_a_stop,
    input  logic          i_player_b_stop,
    output logic [TW-1:0] o_player_a_time,
    output logic [TW-1:0] o_player_b_time,
    output logic          o_player_a_zero,
    output logic          o_player_b_zero,
    output logic [1:0]    o_mode,
    output logic          o_running
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_READY, S_PLAY, S_OVER} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d, mode_inc;
    logic [TW-1:0]   time_a_q, time_a_d, time_b_q, time_b_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            run_a_q, run_b_q;
    logic            run_a, run_b, turn_to_b, turn_to_a, counting;
    logic [TW:0]     sum_a, sum_b;

    function automatic logic [TW-1:0] base_of(input logic [1:0] m);
        logic [TW-1:0] b;
        b = TW'(BASE0);
        case (m)
            2'd1:    b = TW'(BASE1);
            2'd2:    b = TW'(BASE2);
            2'd3:    b = TW'(BASE3);
            default: b = TW'(BASE0);
        endcase
        return b;
    endfunction

    function automatic logic [TW-1:0] inc_of(input logic [1:0] m);
        logic [TW-1:0] v;
        v = TW'(INC0);
        case (m)
            2'd1:    v = TW'(INC1);
            2'd2:    v = TW'(INC2);
            2'd3:    v = TW'(INC3);
            default: v = TW'(INC0);
        endcase
        return v;
    endfunction

    assign run_a     = ~i_player_a_stop;
    assign run_b     = ~i_player_b_stop;
    // A turn change is the previous runner stopping while the other starts in the same cycle
    assign turn_to_b = run_a_q & run_b & ~run_a;
    assign turn_to_a = run_b_q & run_a & ~run_b;
    assign mode_inc  = mode_q + 2'd1;
    assign sum_a     = {1'b0, time_a_q} + {1'b0, inc_of(mode_q)};
    assign sum_b     = {1'b0, time_b_q} + {1'b0, inc_of(mode_q)};

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        time_a_d = time_a_q;
        time_b_d = time_b_q;
        pre_d    = pre_q;
        counting = 1'b0;

        if (i_restart) begin
            state_d  = S_READY;
            time_a_d = base_of(mode_q);
            time_b_d = base_of(mode_q);
            pre_d    = '0;
        end else begin
            case (state_q)
                S_READY: begin
                    if (i_mode_next) begin
                        mode_d   = mode_inc;
                        time_a_d = base_of(mode_inc);
                        time_b_d = base_of(mode_inc);
                    end else if (run_a | run_b) begin
                        state_d  = S_PLAY;
                        counting = 1'b1;
                    end
                end
                S_PLAY:  counting = 1'b1;
                default: ;
            endcase
        end

        if (counting) begin
            if (turn_to_b) begin
                time_a_d = sum_a[TW] ? {TW{1'b1}} : sum_a[TW-1:0];
                pre_d    = '0;
            end else if (turn_to_a) begin
                time_b_d = sum_b[TW] ? {TW{1'b1}} : sum_b[TW-1:0];
                pre_d    = '0;
            end else if (run_a ^ run_b) begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (run_a && time_a_q != '0) time_a_d = time_a_q - 1'b1;
                    if (run_b && time_b_q != '0) time_b_d = time_b_q - 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            if (time_a_d == '0 || time_b_d == '0) state_d = S_OVER;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_READY;
            mode_q   <= 2'd0;
            time_a_q <= TW'(BASE0);
            time_b_q <= TW'(BASE0);
            pre_q    <= '0;
            run_a_q  <= 1'b0;
            run_b_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            time_a_q <= time_a_d;
            time_b_q <= time_b_d;
            pre_q    <= pre_d;
            run_a_q  <= run_a;
            run_b_q  <= run_b;
        end
    end

    assign o_player_a_time = time_a_q;
    assign o_player_b_time = time_b_q;
    assign o_player_a_zero = (time_a_q == '0);
    assign o_player_b_zero = (time_b_q == '0);
    assign o_mode          = mode_q;
    assign o_running       = (state_q == S_PLAY) && (run_a ^ run_b);

endmodule

// File: tb/tb_chess_clock_time_ctrl.sv
// tb/tb_chess_clock_time_ctrl.sv - randomized bench for chess_clock_time_ctrl against a behavioural model
module tb_chess_clock_time_ctrl;

    localparam int CLK_DIV = 4;
    localparam int TW      = 8;
    localparam int TMAX    = (1 << TW) - 1;
    localparam int M_READY = 0;
    localparam int M_PLAY  = 1;
    localparam int M_OVER  = 2;

    int base_tab[4] = '{5, 180, 250, 60};
    int inc_tab[4]  = '{0, 2, 3, 7};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          restart = 1'b0;
    logic          mode_next = 1'b0;
    logic          stop_a = 1'b1;
    logic          stop_b = 1'b1;
    logic [TW-1:0] time_a, time_b;
    logic          zero_a, zero_b, running;
    logic [1:0]    mode;

    int n_cmp = 0;
    int n_err = 0;

    int m_state, m_mode, m_ta, m_tb, m_frac;
    bit m_pa, m_pb;

    chess_clock_time_ctrl #(
        .CLK_DIV(CLK_DIV), .TW(TW),
        .BASE0(5),   .INC0(0),
        .BASE1(180), .INC1(2),
        .BASE2(250), .INC2(3),
        .BASE3(60),  .INC3(7)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_restart       (restart),
        .i_mode_next     (mode_next),
        .i_player_a_stop (stop_a),
        .i_player_b_stop (stop_b),
        .o_player_a_time (time_a),
        .o_player_b_time (time_b),
        .o_player_a_zero (zero_a),
        .o_player_b_zero (zero_b),
        .o_mode          (mode),
        .o_running       (running)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_add(input int t, input int inc);
        return (t + inc > TMAX) ? TMAX : t + inc;
    endfunction

    // One clock of the game as described by the rules, using the inputs present at the edge
    task automatic model_step();
        bit ra, rb;
        ra = !stop_a;
        rb = !stop_b;
        if (!rst_n) begin
            m_state = M_READY; m_mode = 0;
            m_ta = base_tab[0]; m_tb = base_tab[0];
            m_frac = 0; m_pa = 0; m_pb = 0;
        end else begin
            if (restart) begin
                m_state = M_READY;
                m_ta = base_tab[m_mode]; m_tb = base_tab[m_mode];
                m_frac = 0;
            end else if (m_state == M_READY && mode_next) begin
                m_mode = (m_mode + 1) % 4;
                m_ta = base_tab[m_mode]; m_tb = base_tab[m_mode];
            end else if (m_state == M_PLAY || (m_state == M_READY && (ra || rb))) begin
                m_state = M_PLAY;
                if (m_pa && rb && !ra) begin
                    m_ta = sat_add(m_ta, inc_tab[m_mode]);
                    m_frac = 0;
                end else if (m_pb && ra && !rb) begin
                    m_tb = sat_add(m_tb, inc_tab[m_mode]);
                    m_frac = 0;
                end else if (ra != rb) begin
                    m_frac++;
                    if (m_frac == CLK_DIV) begin
                        m_frac = 0;
                        if (ra && m_ta > 0) m_ta--;
                        if (rb && m_tb > 0) m_tb--;
                    end
                end
                if (m_ta == 0 || m_tb == 0) m_state = M_OVER;
            end
            m_pa = ra;
            m_pb = rb;
        end
    endtask

    task automatic check_all();
        check_eq("time_a", int'(time_a), m_ta);
        check_eq("time_b", int'(time_b), m_tb);
        check_eq("zero_a", int'(zero_a), int'(m_ta == 0));
        check_eq("zero_b", int'(zero_b), int'(m_tb == 0));
        check_eq("mode", int'(mode), m_mode);
        check_eq("running", int'(running), int'(m_state == M_PLAY && (stop_a != stop_b)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_kind(input int kind);
        case (kind)
            0:       begin stop_a = 1'b0; stop_b = 1'b1; end
            1:       begin stop_a = 1'b1; stop_b = 1'b0; end
            2:       begin stop_a = 1'b1; stop_b = 1'b1; end
            default: begin stop_a = 1'b0; stop_b = 1'b0; end
        endcase
    endtask

    initial begin
        int kind, r, len;
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        repeat (4) begin
            mode_next = 1'b1; cycle();
            mode_next = 1'b0; cycle();
        end

        // Mode 2 with a turn change every cycle drives the outgoing time into saturation
        restart = 1'b1; cycle(); restart = 1'b0;
        repeat (2) begin mode_next = 1'b1; cycle(); mode_next = 1'b0; cycle(); end
        for (int i = 0; i < 12; i++) begin
            set_kind(i % 2);
            cycle();
        end

        for (int g = 0; g < 60; g++) begin
            set_kind(2);
            if ($urandom_range(0, 3) == 0) rst_n = 1'b0;
            else restart = 1'b1;
            cycle();
            rst_n = 1'b1;
            restart = 1'b0;
            repeat ($urandom_range(0, 5)) begin
                mode_next = 1'b1; cycle();
                mode_next = 1'b0; cycle();
            end
            kind = $urandom_range(0, 1);
            len = $urandom_range(30, 300);
            for (int c = 0; c < len; c++) begin
                r = $urandom_range(0, 999);
                restart = 1'b0;
                mode_next = 1'b0;
                rst_n = 1'b1;
                if (r < 80) kind = (kind == 0) ? 1 : (kind == 1) ? 0 : $urandom_range(0, 1);
                else if (r < 110) kind = 2;
                else if (r < 120) kind = 3;
                else if (r < 150) mode_next = 1'b1;
                else if (r < 155) restart = 1'b1;
                else if (r < 158) rst_n = 1'b0;
                set_kind(kind);
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
